// File: rtl/kw_search_pkg.sv
// Shared constants for the keyword search result path: FSM encoding, default
// response strings/keeps and the statistics counter width.
package kw_search_pkg;

  typedef logic [1:0] kw_state_t;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SEND     = 2'd1;
  localparam logic [1:0] ST_STATS    = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW = 2'd3;

  // ASCII strings are byte-reversed so the first character lands in byte lane 0.
  localparam logic [63:0] KW_MATCH_STR     = 64'h000000686374614D;
  localparam logic [7:0]  KW_MATCH_KEEP    = 8'h1F;
  localparam logic [63:0] KW_NO_MATCH_STR  = 64'h686374616D206F4E;
  localparam logic [7:0]  KW_NO_MATCH_KEEP = 8'hFF;

  localparam int KW_CNT_W = 32;

endpackage

// File: rtl/keyword_result_tx.sv
// Turns matcher result levels into a one-beat AXI-Stream response frame.
// Define KW_RESULT_STATS_EN to append a second beat carrying result counters.
module keyword_result_tx
  import kw_search_pkg::*;
#(
  parameter logic [63:0] MATCH_STR     = KW_MATCH_STR,
  parameter logic [7:0]  MATCH_KEEP    = KW_MATCH_KEEP,
  parameter logic [63:0] NO_MATCH_STR  = KW_NO_MATCH_STR,
  parameter logic [7:0]  NO_MATCH_KEEP = KW_NO_MATCH_KEEP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        match_sig,
  input  logic        no_match_sig,
  output logic        ack,
  output logic [63:0] m_axis_res_tdata,
  output logic [7:0]  m_axis_res_tkeep,
  output logic        m_axis_res_tvalid,
  input  logic        m_axis_res_tready,
  output logic        m_axis_res_tlast,
  output logic        m_axis_res_tuser,
  output logic [1:0]  dbg_state
);

  // Handshake: a beat moves on a rising edge where tvalid=1 and tready=1;
  // once raised, tvalid and the beat contents hold until that edge.

`ifdef KW_RESULT_STATS_EN
  localparam logic FIRST_LAST = 1'b0;
`else
  localparam logic FIRST_LAST = 1'b1;
`endif

  kw_state_t   state_q, state_d;
  logic        ack_q, ack_d;
  logic        tvalid_q, tvalid_d;
  logic [63:0] tdata_q, tdata_d;
  logic [7:0]  tkeep_q, tkeep_d;
  logic        tlast_q, tlast_d;
  logic        xfer;

`ifdef KW_RESULT_STATS_EN
  logic [KW_CNT_W-1:0] match_count_q, match_count_d;
  logic [KW_CNT_W-1:0] no_match_count_q, no_match_count_d;
`endif

  assign xfer = tvalid_q & m_axis_res_tready;

  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
`ifdef KW_RESULT_STATS_EN
    match_count_d    = match_count_q;
    no_match_count_d = no_match_count_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (match_sig || no_match_sig) begin
          state_d  = ST_SEND;
          ack_d    = 1'b1;
          tvalid_d = 1'b1;
          tlast_d  = FIRST_LAST;
          // match_sig wins a simultaneous report and counts only as a match.
          if (match_sig) begin
            tdata_d = MATCH_STR;
            tkeep_d = MATCH_KEEP;
`ifdef KW_RESULT_STATS_EN
            match_count_d = match_count_q + 1'b1;
`endif
          end else begin
            tdata_d = NO_MATCH_STR;
            tkeep_d = NO_MATCH_KEEP;
`ifdef KW_RESULT_STATS_EN
            no_match_count_d = no_match_count_q + 1'b1;
`endif
          end
        end
      end
      ST_SEND: begin
        if (xfer) begin
`ifdef KW_RESULT_STATS_EN
          // Counters were bumped at detection, so this beat reports post-increment values.
          state_d = ST_STATS;
          tdata_d = {no_match_count_q, match_count_q};
          tkeep_d = 8'hFF;
          tlast_d = 1'b1;
`else
          state_d  = ST_WAIT_LOW;
          tvalid_d = 1'b0;
          tdata_d  = 64'd0;
          tkeep_d  = 8'd0;
          tlast_d  = 1'b0;
`endif
        end
      end
`ifdef KW_RESULT_STATS_EN
      ST_STATS: begin
        if (xfer) begin
          state_d  = ST_WAIT_LOW;
          tvalid_d = 1'b0;
          tdata_d  = 64'd0;
          tkeep_d  = 8'd0;
          tlast_d  = 1'b0;
        end
      end
`endif
      ST_WAIT_LOW: begin
        // A result level still held from the last frame must not retrigger.
        if (!match_sig && !no_match_sig) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
        tdata_d  = 64'd0;
        tkeep_d  = 8'd0;
        tlast_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ack_q    <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= 64'd0;
      tkeep_q  <= 8'd0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
    end
  end

`ifdef KW_RESULT_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_count_q    <= '0;
      no_match_count_q <= '0;
    end else begin
      match_count_q    <= match_count_d;
      no_match_count_q <= no_match_count_d;
    end
  end
`endif

  assign ack               = ack_q;
  assign m_axis_res_tvalid = tvalid_q;
  assign m_axis_res_tdata  = tdata_q;
  assign m_axis_res_tkeep  = tkeep_q;
  assign m_axis_res_tlast  = tlast_q;
  assign m_axis_res_tuser  = 1'b0;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_keyword_result_tx.sv
// Directed bench for keyword_result_tx; define KW_RESULT_STATS_EN for the
// two-beat (statistics) build.
module tb_keyword_result_tx;

  localparam logic [63:0] M_STR  = 64'h000000686374614D;
  localparam logic [7:0]  M_KEEP = 8'h1F;
  localparam logic [63:0] N_STR  = 64'h686374616D206F4E;
  localparam logic [7:0]  N_KEEP = 8'hFF;
`ifdef KW_RESULT_STATS_EN
  localparam logic [63:0] FIRST_LAST = 64'd0;
  localparam int          BEATS      = 2;
`else
  localparam logic [63:0] FIRST_LAST = 64'd1;
  localparam int          BEATS      = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        match_sig = 1'b0;
  logic        no_match_sig = 1'b0;
  logic        ack;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tready = 1'b0;
  logic        tlast;
  logic        tuser;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int ack_cnt = 0;
  int xfer_base;
  int ack_base;

  keyword_result_tx dut (
    .clk               (clk),
    .reset             (reset),
    .match_sig         (match_sig),
    .no_match_sig      (no_match_sig),
    .ack               (ack),
    .m_axis_res_tdata  (tdata),
    .m_axis_res_tkeep  (tkeep),
    .m_axis_res_tvalid (tvalid),
    .m_axis_res_tready (tready),
    .m_axis_res_tlast  (tlast),
    .m_axis_res_tuser  (tuser),
    .dbg_state         (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Inputs change 2 time units after a rising edge, so at the falling edge the
  // sampled tvalid/tready describe the handshake at the next rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (tvalid && tready) xfer_cnt++;
      if (ack) ack_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic mark();
    xfer_base = xfer_cnt;
    ack_base  = ack_cnt;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic check_beat(input string tag, input logic [63:0] d, input logic [7:0] k,
                            input logic [63:0] last, input logic [63:0] a);
    check({tag, "_valid"}, {63'd0, tvalid}, 64'd1);
    check({tag, "_data"}, tdata, d);
    check({tag, "_keep"}, {56'd0, tkeep}, {56'd0, k});
    check({tag, "_last"}, {63'd0, tlast}, last);
    check({tag, "_ack"}, {63'd0, ack}, a);
  endtask

  // After the first beat transferred: in the stats build, step over the stats beat.
  task automatic finish_frame(input string tag);
`ifdef KW_RESULT_STATS_EN
    check({tag, "_stats_valid"}, {63'd0, tvalid}, 64'd1);
    check({tag, "_stats_last"}, {63'd0, tlast}, 64'd1);
    check({tag, "_stats_keep"}, {56'd0, tkeep}, 64'hFF);
    step();
`endif
    check({tag, "_idle_valid"}, {63'd0, tvalid}, 64'd0);
  endtask

  // Single frame with tready=1 in the stats build; checks the stats payload.
  task automatic stats_frame(input string tag, input logic is_match, input logic [63:0] stats);
    match_sig    = is_match;
    no_match_sig = ~is_match;
    tready       = 1'b1;
    step();
    check_beat({tag, "_b0"}, is_match ? M_STR : N_STR, is_match ? M_KEEP : N_KEEP, FIRST_LAST, 64'd1);
    step();
    check({tag, "_b1_data"}, tdata, stats);
    check({tag, "_b1_last"}, {63'd0, tlast}, 64'd1);
    step();
    check({tag, "_end_valid"}, {63'd0, tvalid}, 64'd0);
    match_sig    = 1'b0;
    no_match_sig = 1'b0;
    step();
  endtask

  initial begin
    // reset state
    #2;
    check("rst_valid", {63'd0, tvalid}, 64'd0);
    check("rst_ack", {63'd0, ack}, 64'd0);
    check("rst_data", tdata, 64'd0);
    check("rst_keep", {56'd0, tkeep}, 64'd0);
    check("rst_last", {63'd0, tlast}, 64'd0);
    check("rst_user", {63'd0, tuser}, 64'd0);
    step();
    reset = 1'b0;
    step();
    check("idle_valid", {63'd0, tvalid}, 64'd0);

    // match held, tready=1: one beat, one ack
    mark();
    match_sig = 1'b1;
    tready    = 1'b1;
    step();
    check_beat("m1", M_STR, M_KEEP, FIRST_LAST, 64'd1);
    step();
    finish_frame("m1");
    check("m1_ack_low", {63'd0, ack}, 64'd0);
    step();
    match_sig = 1'b0;
    check("m1_held_valid", {63'd0, tvalid}, 64'd0);
    step();
    step();
    check("m1_xfers", 64'(xfer_cnt - xfer_base), 64'(BEATS));
    check("m1_acks", 64'(ack_cnt - ack_base), 64'd1);

    // no-match with 5 cycles of back-pressure
    mark();
    no_match_sig = 1'b1;
    tready       = 1'b0;
    step();
    check_beat("nm_c0", N_STR, N_KEEP, FIRST_LAST, 64'd1);
    for (int i = 1; i < 5; i++) begin
      step();
      check_beat($sformatf("nm_c%0d", i), N_STR, N_KEEP, FIRST_LAST, 64'd0);
    end
    step();
    tready = 1'b1;
    check_beat("nm_c5", N_STR, N_KEEP, FIRST_LAST, 64'd0);
    step();
    finish_frame("nm");
    step();
    no_match_sig = 1'b0;
    step();
    step();
    check("nm_xfers", 64'(xfer_cnt - xfer_base), 64'(BEATS));
    check("nm_acks", 64'(ack_cnt - ack_base), 64'd1);

    // both inputs high: match wins, no retrigger while held
    mark();
    match_sig    = 1'b1;
    no_match_sig = 1'b1;
    step();
    check_beat("both", M_STR, M_KEEP, FIRST_LAST, 64'd1);
    step();
    finish_frame("both");
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("both_hold%0d", i), {63'd0, tvalid}, 64'd0);
    end
    match_sig    = 1'b0;
    no_match_sig = 1'b0;
    step();
    step();
    check("both_xfers", 64'(xfer_cnt - xfer_base), 64'(BEATS));
    check("both_acks", 64'(ack_cnt - ack_base), 64'd1);

    // asynchronous reset mid-frame
    match_sig = 1'b1;
    tready    = 1'b0;
    step();
    check("rmid_valid_pre", {63'd0, tvalid}, 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check("rmid_valid", {63'd0, tvalid}, 64'd0);
    check("rmid_ack", {63'd0, ack}, 64'd0);
    check("rmid_data", tdata, 64'd0);
    check("rmid_keep", {56'd0, tkeep}, 64'd0);
    check("rmid_last", {63'd0, tlast}, 64'd0);
    match_sig = 1'b0;
    step();
    reset = 1'b0;
    step();
    mark();
    match_sig = 1'b1;
    tready    = 1'b1;
    step();
    check_beat("post_rst", M_STR, M_KEEP, FIRST_LAST, 64'd1);
    step();
    finish_frame("post_rst");
    match_sig = 1'b0;
    step();
    step();
    check("post_rst_xfers", 64'(xfer_cnt - xfer_base), 64'(BEATS));
    check("post_rst_state", {62'd0, dbg_state}, 64'd0);

`ifdef KW_RESULT_STATS_EN
    // counters: fresh start, 2 matches then 1 no-match
    pulse_reset();
    stats_frame("st1", 1'b1, 64'h0000000000000001);
    stats_frame("st2", 1'b1, 64'h0000000000000002);
    stats_frame("st3", 1'b0, 64'h0000000100000002);
    // match counter wrap
    force dut.match_count_q = 32'hFFFFFFFF;
    #1;
    release dut.match_count_q;
    stats_frame("wrap", 1'b1, 64'h0000000100000000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keyword_result_tx.md
KEYWORD_RESULT_TX -- requirements
Module: keyword_result_tx

Interface
REQ-001 SHALL have parameter MATCH_STR, default 64'h000000686374614D, "Match" byte-reversed for the stream.
REQ-002 SHALL have parameter MATCH_KEEP, default 8'h1F, tkeep for the match beat.
REQ-003 SHALL have parameter NO_MATCH_STR, default 64'h686374616D206F4E, "No match" byte-reversed for the stream.
REQ-004 SHALL have parameter NO_MATCH_KEEP, default 8'hFF, tkeep for the no-match beat.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port match_sig, input, 1, level from the keyword matcher meaning keyword found.
REQ-008 SHALL have port no_match_sig, input, 1, level from the keyword matcher meaning frame ended without a match.
REQ-009 SHALL have port ack, output, 1, one-cycle acknowledge back to the matcher.
REQ-010 SHALL have port m_axis_res_tdata, output, 64, response payload.
REQ-011 SHALL have port m_axis_res_tkeep, output, 8, byte enables.
REQ-012 SHALL have port m_axis_res_tvalid, output, 1, beat valid.
REQ-013 SHALL have port m_axis_res_tready, input, 1, downstream ready.
REQ-014 SHALL have port m_axis_res_tlast, output, 1, last beat of the response frame.
REQ-015 SHALL have port m_axis_res_tuser, output, 1, driven 0 at all times.

Function
REQ-016 SHALL implement the FSM states IDLE, SEND, STATS and WAIT_LOW, with STATS present only under REQ-029.
REQ-017 SHALL, in IDLE with match_sig=1 or no_match_sig=1 at edge N, latch the result type, go to SEND, and drive ack=1 and tvalid=1 from cycle N+1.
REQ-018 SHALL hold ack high for exactly one cycle per detected result, regardless of tready.
REQ-019 SHALL give match_sig priority when both inputs are high in the same IDLE cycle; that event counts as one match only.
REQ-020 SHALL, in SEND, drive tdata, tkeep and tlast as registered outputs that stay constant while tvalid=1 and tready=0.
REQ-021 SHALL drive tdata/tkeep in SEND as MATCH_STR/MATCH_KEEP for a match and NO_MATCH_STR/NO_MATCH_KEEP for a no-match.
REQ-022 SHALL drive tlast=1 in SEND when REQ-029 is off.
REQ-023 SHALL treat a beat as transferred only on a cycle where tvalid=1 and tready=1; tvalid SHALL NOT drop before transfer.
REQ-024 SHALL, when tready=1 in the first SEND cycle, transfer the beat in that cycle; minimum frame latency is 1 cycle from detection.
REQ-025 SHALL go to WAIT_LOW on transfer of the last beat, with tvalid=0 the next cycle.
REQ-026 SHALL stay in WAIT_LOW until match_sig=0 and no_match_sig=0 in the same cycle, then return to IDLE, so a held level never produces a second response.
REQ-027 SHALL ignore input levels in SEND, STATS and WAIT_LOW, with no queuing.

Reset
REQ-028 SHALL, on reset asserted at any time including mid-frame, immediately force state=IDLE, ack=0, tvalid=0, tlast=0, tdata=0, tkeep=0 and tuser=0, clear all counters, and discard any in-flight beat.

Configuration
REQ-029 SHALL, with macro KW_RESULT_STATS_EN defined, keep 32-bit match_count and no_match_count counters that each increment on detection and wrap from 2^32-1 to 0.
REQ-030 SHALL, with KW_RESULT_STATS_EN defined, send SEND with tlast=0, then a STATS beat with tdata={no_match_count,match_count} (post-increment), tkeep=8'hFF and tlast=1.
REQ-031 SHALL, without KW_RESULT_STATS_EN, have no counters, no STATS state and single-beat frames.

Structure
REQ-032 SHALL place the state encoding, the default string and keep constants, and the counter width constant in the shared package kw_search_pkg.
REQ-033 SHALL contain no sub-module; the FSM and the output registers are a single module.

Verification
REQ-034 SHALL cover: match_sig pulse held 3 cycles, tready=1 -> one ack pulse at N+1, and one beat 64'h000000686374614D with keep 8'h1F and tlast=1.
REQ-035 SHALL cover: no_match_sig high, tready=0 for 5 cycles then 1 -> the beat 64'h686374616D206F4E with keep 8'hFF is stable for 6 cycles, ack=1 only in the first, and exactly one transfer.
REQ-036 SHALL cover: match_sig=1 and no_match_sig=1 together -> a match response only, and no second frame while both stay high.
REQ-037 SHALL cover: reset asserted while tvalid=1 and tready=0 -> tvalid=0 with no clock edge, and after release a fresh match produces a normal frame.
REQ-038 SHALL cover (KW_RESULT_STATS_EN): 2 matches then 1 no-match -> third frame second beat tdata=64'h0000000100000002 with tlast=1.
REQ-039 SHALL cover (KW_RESULT_STATS_EN): match_count preloaded by forcing it to 32'hFFFFFFFF, then one match -> stats low word 32'h00000000.
